// File: rtl/rf_pkg.sv
// Shared definitions for the 8x8 dual-write register file and its write-back scheduler.
package rf_pkg;

    localparam int unsigned DWIDTH = 8;
    localparam int unsigned AWIDTH = 3;
    localparam int unsigned NREG   = 1 << AWIDTH;

    typedef struct packed {
        logic [AWIDTH-1:0] index;
        logic [DWIDTH-1:0] data;
    } wr_req_t;

    function automatic logic [NREG-1:0] reg_onehot(input logic [AWIDTH-1:0] idx);
        return NREG'(1) << idx;
    endfunction

endpackage

// File: rtl/wq_fifo.sv
// In-order write queue with a two-entry peek (E0 = head, E1 = head+1) and a 0/1/2 pop.
module wq_fifo #(
    parameter int unsigned W     = 11,
    parameter int unsigned TW    = 3,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic [1:0]               pop_cnt,
    output logic [W-1:0]             e0,
    output logic [W-1:0]             e1,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic [DEPTH-1:0]         valid,
    output logic [DEPTH*TW-1:0]      tags
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        rd_ptr_d = rd_ptr_q + PW'(pop_cnt);
        count_d  = count_q + CW'(push) - CW'(pop_cnt);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; the valid vector qualifies every slot.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        logic [PW-1:0] off;
        off   = '0;
        valid = '0;
        tags  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off                 = PW'(i) - rd_ptr_q;
            valid[i]            = ({1'b0, off} < count_q);
            tags[i*TW +: TW]    = mem_q[i][W-1 -: TW];
        end
    end

    assign e0    = mem_q[rd_ptr_q];
    assign e1    = mem_q[rd_ptr_q + PW'(1)];
    assign count = count_q;
    assign full  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/rf_write_scheduler.sv
// Buffers single write requests and issues up to two per cycle onto the register file's
// A/B write ports, coalescing back-to-back writes to the same register.
module rf_write_scheduler #(
    parameter int unsigned DWIDTH = rf_pkg::DWIDTH,
    parameter int unsigned AWIDTH = rf_pkg::AWIDTH,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [AWIDTH-1:0]   in_index,
    input  logic [DWIDTH-1:0]   in_data,
    input  logic                issue_en,
    output logic                wen,
    output logic [AWIDTH-1:0]   a_index,
    output logic [DWIDTH-1:0]   a_data,
    output logic [AWIDTH-1:0]   b_index,
    output logic [DWIDTH-1:0]   b_data,
    output logic [(1<<AWIDTH)-1:0] pend_mask
);

    localparam int unsigned NREG = 1 << AWIDTH;
    localparam int unsigned W    = AWIDTH + DWIDTH;
    localparam int unsigned CW   = $clog2(DEPTH) + 1;

    logic                    push;
    logic [1:0]              pop_cnt;
    logic [W-1:0]            e0, e1;
    logic [CW-1:0]           count;
    logic                    full;
    logic [DEPTH-1:0]        valid;
    logic [DEPTH*AWIDTH-1:0] tags;

    logic [AWIDTH-1:0] e0_index, e1_index;
    logic [DWIDTH-1:0] e0_data, e1_data;

    // No push while in reset or full, even if a pop frees a slot this cycle.
    assign in_ready = rst_n && !full;
    assign push     = in_valid && in_ready;

    wq_fifo #(
        .W     (W),
        .TW    (AWIDTH),
        .DEPTH (DEPTH)
    ) u_wq_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({in_index, in_data}),
        .pop_cnt   (pop_cnt),
        .e0        (e0),
        .e1        (e1),
        .count     (count),
        .full      (full),
        .valid     (valid),
        .tags      (tags)
    );

    assign {e0_index, e0_data} = e0;
    assign {e1_index, e1_data} = e1;

    always_comb begin
        wen     = 1'b0;
        pop_cnt = 2'd0;
        a_index = e0_index;
        a_data  = e0_data;
        b_index = e1_index;
        b_data  = e1_data;
        if (issue_en && count != '0) begin
            wen = 1'b1;
            if (count == CW'(1)) begin
                b_index = e0_index;
                b_data  = e0_data;
                pop_cnt = 2'd1;
            end else if (e0_index == e1_index) begin
                // Younger value wins; the older write to the same register is dropped.
                a_index = e1_index;
                a_data  = e1_data;
                pop_cnt = 2'd2;
            end else begin
                pop_cnt = 2'd2;
            end
        end
    end

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i]) begin
                pend_mask[tags[i*AWIDTH +: AWIDTH]] = 1'b1;
            end
        end
    end

    // Compile-time sanity on the queue geometry.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two and at least 2");
    end
    if (NREG != rf_pkg::NREG && AWIDTH == rf_pkg::AWIDTH) begin : g_bad_nreg
        $error("NREG disagrees with rf_pkg");
    end

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Directed bench: expected issue tuples are queued with the stimulus and checked when wen fires.
module tb_rf_write_scheduler;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_index;
    logic [7:0] in_data;
    logic       issue_en;
    logic       wen;
    logic [2:0] a_index;
    logic [7:0] a_data;
    logic [2:0] b_index;
    logic [7:0] b_data;
    logic [7:0] pend_mask;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] ai;
        logic [7:0] ad;
        logic [2:0] bi;
        logic [7:0] bd;
    } iss_t;

    iss_t       sb[$];
    iss_t       mon_e;
    logic [7:0] rf_model [8];

    rf_write_scheduler #(
        .DWIDTH (8),
        .AWIDTH (3),
        .DEPTH  (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_index  (in_index),
        .in_data   (in_data),
        .issue_en  (issue_en),
        .wen       (wen),
        .a_index   (a_index),
        .a_data    (a_data),
        .b_index   (b_index),
        .b_data    (b_data),
        .pend_mask (pend_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic req(input logic v, input logic [2:0] idx, input logic [7:0] dat);
        in_valid = v;
        in_index = idx;
        in_data  = dat;
    endtask

    task automatic expect_issue(input logic [2:0] ai, input logic [7:0] ad,
                                input logic [2:0] bi, input logic [7:0] bd);
        iss_t e;
        e.ai = ai;
        e.ad = ad;
        e.bi = bi;
        e.bd = bd;
        sb.push_back(e);
    endtask

    // Issue monitor: every write-enabled cycle must match the oldest expected tuple.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && wen === 1'b1) begin
            chk("issue_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("a_index", 32'(a_index), 32'(mon_e.ai));
                chk("a_data",  32'(a_data),  32'(mon_e.ad));
                chk("b_index", 32'(b_index), 32'(mon_e.bi));
                chk("b_data",  32'(b_data),  32'(mon_e.bd));
            end
            rf_model[a_index] = a_data;
            rf_model[b_index] = b_data;
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 8; i++) rf_model[i] = 8'h00;

        // Reset held for two edges with a request presented.
        rst_n    = 1'b0;
        issue_en = 1'b0;
        req(1'b1, 3'd7, 8'h77);
        #1;
        chk("rst_in_ready_0", 32'(in_ready), 32'd0);
        sample();
        chk("rst_in_ready_1", 32'(in_ready), 32'd0);
        cyc();
        rst_n = 1'b1;
        req(1'b0, 3'd0, 8'h00);
        sample();
        chk("post_rst_wen", 32'(wen), 32'd0);
        chk("post_rst_pend", 32'(pend_mask), 32'h00);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Single write.
        cyc();
        issue_en = 1'b1;
        req(1'b1, 3'd5, 8'hA5);
        expect_issue(3'd5, 8'hA5, 3'd5, 8'hA5);
        cyc();
        req(1'b0, 3'd0, 8'h00);
        sample();
        chk("single_wen", 32'(wen), 32'd1);
        chk("single_pend", 32'(pend_mask), 32'h20);
        cyc();
        sample();
        chk("single_wen_after", 32'(wen), 32'd0);
        chk("single_pend_after", 32'(pend_mask), 32'h00);

        // Dual issue.
        cyc();
        issue_en = 1'b0;
        req(1'b1, 3'd1, 8'h11);
        cyc();
        req(1'b1, 3'd2, 8'h22);
        cyc();
        req(1'b0, 3'd0, 8'h00);
        sample();
        chk("dual_pend", 32'(pend_mask), 32'h06);
        chk("dual_wen_held", 32'(wen), 32'd0);
        expect_issue(3'd1, 8'h11, 3'd2, 8'h22);
        cyc();
        issue_en = 1'b1;
        sample();
        chk("dual_wen", 32'(wen), 32'd1);
        cyc();
        sample();
        chk("dual_wen_after", 32'(wen), 32'd0);
        chk("dual_pend_after", 32'(pend_mask), 32'h00);

        // Coalesce two writes to register 3.
        cyc();
        issue_en = 1'b0;
        req(1'b1, 3'd3, 8'h01);
        cyc();
        req(1'b1, 3'd3, 8'h02);
        cyc();
        req(1'b0, 3'd0, 8'h00);
        sample();
        chk("coal_pend", 32'(pend_mask), 32'h08);
        expect_issue(3'd3, 8'h02, 3'd3, 8'h02);
        cyc();
        issue_en = 1'b1;
        sample();
        chk("coal_wen", 32'(wen), 32'd1);
        cyc();
        sample();
        chk("coal_wen_after", 32'(wen), 32'd0);
        chk("coal_pend_after", 32'(pend_mask), 32'h00);
        chk("coal_rf3", 32'(rf_model[3]), 32'h02);

        // Full queue and backpressure.
        cyc();
        issue_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            req(1'b1, 3'(i), 8'(8'h40 + i));
            sample();
            chk("full_in_ready", 32'(in_ready), (i < 4) ? 32'd1 : 32'd0);
            cyc();
        end
        sample();
        chk("full_held_ready", 32'(in_ready), 32'd0);
        chk("full_pend", 32'(pend_mask), 32'h0F);
        expect_issue(3'd0, 8'h40, 3'd1, 8'h41);
        expect_issue(3'd2, 8'h42, 3'd3, 8'h43);
        expect_issue(3'd4, 8'h44, 3'd4, 8'h44);
        cyc();
        issue_en = 1'b1;
        sample();
        chk("full_pop1_wen", 32'(wen), 32'd1);
        chk("full_pop1_ready", 32'(in_ready), 32'd0);
        cyc();
        sample();
        chk("full_after_pop_ready", 32'(in_ready), 32'd1);
        chk("full_pop2_wen", 32'(wen), 32'd1);
        cyc();
        req(1'b0, 3'd0, 8'h00);
        sample();
        chk("full_last_wen", 32'(wen), 32'd1);
        chk("full_last_pend", 32'(pend_mask), 32'h10);
        cyc();
        sample();
        chk("full_drained_wen", 32'(wen), 32'd0);
        chk("full_drained_pend", 32'(pend_mask), 32'h00);

        // Reset mid-queue discards everything.
        cyc();
        issue_en = 1'b0;
        req(1'b1, 3'd6, 8'h66);
        cyc();
        req(1'b1, 3'd7, 8'h67);
        cyc();
        req(1'b1, 3'd0, 8'h60);
        cyc();
        req(1'b0, 3'd0, 8'h00);
        sample();
        chk("mid_pend", 32'(pend_mask), 32'hC1);
        cyc();
        rst_n = 1'b0;
        req(1'b1, 3'd5, 8'h55);
        sample();
        chk("mid_rst_ready", 32'(in_ready), 32'd0);
        cyc();
        rst_n    = 1'b1;
        issue_en = 1'b1;
        req(1'b0, 3'd0, 8'h00);
        sample();
        chk("mid_wen", 32'(wen), 32'd0);
        chk("mid_pend_clr", 32'(pend_mask), 32'h00);
        chk("mid_in_ready", 32'(in_ready), 32'd1);
        cyc();
        sample();
        chk("mid_wen_later", 32'(wen), 32'd0);
        chk("mid_pend_later", 32'(pend_mask), 32'h00);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_write_scheduler.md
Name: rf_write_scheduler

Overview:
- Write-back scheduler that sits directly upstream of the 8x8 dual-write/dual-read register file.
- Accepts single write requests (index, data) from producers through a valid/ready handshake and buffers them in order in a small FIFO.
- Issues up to two writes per cycle onto the register file's A/B write ports with its shared write enable.
- Publishes a pending-write mask so read-side logic can stall reads of registers whose writes are still queued.

Parameters:
- DWIDTH, 8, data width of a register entry.
- AWIDTH, 3, register index width; NREG = 2**AWIDTH.
- DEPTH, 4, write queue depth; power of two, minimum 2.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- in_valid  in  1  producer has a write request.
- in_ready  out  1  scheduler can accept a request this cycle.
- in_index  in  AWIDTH  destination register.
- in_data  in  DWIDTH  write data.
- issue_en  in  1  downstream permits issue this cycle; low means no issue.
- wen  out  1  register file write enable.
- a_index  out  AWIDTH  port A index.
- a_data  out  DWIDTH  port A data.
- b_index  out  AWIDTH  port B index.
- b_data  out  DWIDTH  port B data.
- pend_mask  out  NREG  bit r set when any queued entry targets register r.

Behaviour:
- Reset: rst_n sampled low at a clk edge clears wr_ptr, rd_ptr and count. While rst_n is low, in_ready=0. After release: wen=0, pend_mask=0, in_ready=1.
- Reset mid-operation discards all queued entries. A request presented in the reset cycle is not accepted.
- Push: occurs when in_valid && in_ready. in_ready = (count != DEPTH). Pushing into a full queue is not allowed, even if a pop happens in the same cycle.
- Latency: an entry pushed at edge N is visible on the issue outputs and in pend_mask during cycle N+1. There is no same-cycle bypass.
- Issue is combinational from queue state and issue_en. E0 = head (oldest entry), E1 = head+1.
  - count==0 or issue_en==0: wen=0, nothing popped. a_*/b_* still show E0/E1 but are don't-care.
  - count==1: wen=1; a = b = E0 (both ports write identical index and data); pop 1.
  - count>=2 and E0.index != E1.index: wen=1; a=E0, b=E1; pop 2.
  - count>=2 and E0.index == E1.index (coalesce): wen=1; a = b = E1 (younger value wins); pop 2. E0 is dropped.
- Program order: never issue E1 without E0. Entries beyond E1 wait for later cycles.
- Count update: count' = count + push - popped. Pointers wrap modulo DEPTH.
- pend_mask is the OR of a one-hot decode over all valid entries, based on the current state (pre-pop). It is combinational from registered state.
- Widths: count is $clog2(DEPTH)+1 bits. Data passes through unmodified.

Decomposition:
- Shared package rf_pkg holds: DWIDTH=8, AWIDTH=3, NREG=8, and the write-request struct {index, data}. The register file and this block both use it.
- One natural sub-module: wq_fifo, a synchronous FIFO with a two-entry peek (E0, E1), pop count 0/1/2, count and full outputs.
- The issue/coalesce logic and pend_mask decode stay in the top module.

Test Plan:
1. Reset:
   - Stimulus: hold rst_n low for 2 cycles with in_valid=1, in_index=7.
   - Required: in_ready=0 throughout; after release wen=0, pend_mask=0x00, in_ready=1; no entry is queued.
2. Single write:
   - Stimulus: push (5, 0xA5) with issue_en=1.
   - Required: next cycle wen=1, a_index=b_index=5, a_data=b_data=0xA5, pend_mask=0x20. The following cycle wen=0 and pend_mask=0x00.
3. Dual issue:
   - Stimulus: with issue_en=0, push (1, 0x11) then (2, 0x22); pend_mask=0x06. Then raise issue_en.
   - Required: exactly one cycle with wen=1, a=(1, 0x11), b=(2, 0x22); then count=0 and pend_mask=0x00.
4. Coalesce:
   - Stimulus: with issue_en=0, push (3, 0x01) then (3, 0x02). Then raise issue_en.
   - Required: one cycle with a=(3, 0x02), b=(3, 0x02), both entries popped; the register file reads 0x02 at index 3.
5. Full / backpressure:
   - Stimulus: with issue_en=0, present 5 requests to indices 0..4.
   - Required: in_ready falls after the 4th accept and the 5th is held. After raising issue_en: pops of (0, 1) then (2, 3); in_ready=1 in the cycle after the first pop; the 5th request is accepted and issued last.
6. Reset mid-queue:
   - Stimulus: queue 3 entries with issue_en=0; pulse rst_n low for 1 cycle; then set issue_en=1.
   - Required: wen stays 0 and pend_mask=0x00; no stale writes are issued.
